// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache reads and dcache writes onto one AXI master port.
// The one-entry write buffer blocks reads to its line until the B response arrives.
module cache_axi_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [31:0]       ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [31:0]       dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [127:0]      dc_wr_data,
  output logic              dc_wr_rdy,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic [3:0]        wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

  rstate_t rstate, rstate_nxt;
  wstate_t wstate, wstate_nxt;

  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_type;
  logic              rd_owner;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [2:0]        wbuf_type;
  logic [3:0]        wbuf_wstrb;
  logic [127:0]      wbuf_data;
  logic [1:0]        cnt;
  logic              wbuf_busy, ic_block, dc_block, ic_grant, dc_grant, wr_accept, in_rdata;
  logic              rid_unused;

  assign wbuf_busy = wstate != W_IDLE;
  assign ic_block  = wbuf_busy & (ic_rd_addr[ADDR_W-1:4] == wbuf_addr[ADDR_W-1:4]);
  assign dc_block  = wbuf_busy & (dc_rd_addr[ADDR_W-1:4] == wbuf_addr[ADDR_W-1:4]);
  // dcache wins ties; a blocked dcache request does not hold off the icache
  assign dc_grant  = (rstate == R_IDLE) & dc_rd_req & ~dc_block;
  assign ic_grant  = (rstate == R_IDLE) & ic_rd_req & ~ic_block & ~(dc_rd_req & ~dc_block);
  assign dc_rd_rdy = dc_grant;
  assign ic_rd_rdy = ic_grant;
  assign dc_wr_rdy = (wstate == W_IDLE) & ~rst;
  assign wr_accept = dc_wr_req & dc_wr_rdy;

  // Read channel: request latch and AR payload
  always_ff @(posedge clk) begin
    if (dc_grant) begin
      rd_addr  <= dc_rd_addr;
      rd_type  <= dc_rd_type;
      rd_owner <= 1'b1;
    end else if (ic_grant) begin
      rd_addr  <= ic_rd_addr;
      rd_type  <= ic_rd_type;
      rd_owner <= 1'b0;
    end
  end

  assign arid   = {3'b000, rd_owner};
  assign araddr = rd_addr;
  assign arlen  = rd_type[2] ? 8'd3 : 8'd0;
  assign arsize = rd_type[2] ? 3'd2 : {1'b0, rd_type[1:0]};

  assign in_rdata     = rstate == R_DATA;
  assign ic_ret_valid = in_rdata & ~rd_owner & rvalid;
  assign ic_ret_last  = in_rdata & ~rd_owner & rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_valid = in_rdata & rd_owner & rvalid;
  assign dc_ret_last  = in_rdata & rd_owner & rlast;
  assign dc_ret_data  = rdata;
  // Beats are routed by the latched owner, never by rid
  assign rid_unused   = ^rid;

  always_ff @(posedge clk) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (rstate)
      R_IDLE: if (dc_grant | ic_grant) rstate_nxt = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid & rlast) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Write channel: one-entry buffer
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wbuf_addr  <= dc_wr_addr;
      wbuf_type  <= dc_wr_type;
      wbuf_wstrb <= dc_wr_wstrb;
      wbuf_data  <= dc_wr_data;
    end
  end

  assign awid    = 4'd1;
  assign wid     = 4'd1;
  assign awaddr  = wbuf_addr;
  assign awlen   = wbuf_type[2] ? 8'd3 : 8'd0;
  assign awsize  = wbuf_type[2] ? 3'd2 : {1'b0, wbuf_type[1:0]};
  assign wdata   = wbuf_data[{cnt, 5'd0} +: 32];
  assign wstrb   = wbuf_type[2] ? 4'hf : wbuf_wstrb;
  assign wlast   = cnt == awlen[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      cnt    <= 2'd0;
    end else begin
      wstate <= wstate_nxt;
      if (wstate == W_DATA && wready) cnt <= wlast ? 2'd0 : cnt + 2'd1;
    end
  end

  always_comb begin
    wstate_nxt = wstate;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (wstate)
      W_IDLE: if (wr_accept) wstate_nxt = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready & wlast) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'h0;
  assign awcache = 4'h0;
  assign arprot  = 3'h0;
  assign awprot  = {2'b00, rid_unused & 1'b0};

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: read and write beats are checked
// against scoreboard queues filled when the stimulus is driven.
module tb_cache_axi_arbiter;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0] ic_rd_type, dc_rd_type, dc_wr_type;
  logic [ADDR_W-1:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last;
  logic [31:0] ic_ret_data, dc_ret_data;
  logic [3:0] dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic dc_wr_rdy;
  logic [3:0] arid, rid, awid, wid, wstrb, arcache, awcache;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [1:0] arburst, awburst, arlock, awlock;
  logic [31:0] rdata, wdata;
  logic wlast, wvalid, wready, bvalid, bready;

  int n_asrt = 0;
  int n_fail = 0;
  logic [33:0] rq[$];
  logic [31:0] wq[$];

  cache_axi_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .arid(arid), .arlen(arlen), .arsize(arsize), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called the cycle after a read was accepted
  task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
    #1;
    chk("arvalid", arvalid, 1);
    chk("arid", arid, id);
    chk("araddr", araddr, addr);
    chk("arlen", arlen, len);
    chk("arsize", arsize, size);
    chk("rdy_outside_idle", {ic_rd_rdy, dc_rd_rdy}, 0);
    arready = 1'b1;
    tick;
    arready = 1'b0;
  endtask

  task automatic r_beats(input bit own, input int n, input logic [31:0] base, input logic [3:0] id);
    logic [33:0] e;
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = base + i;
      rlast  = (i == n - 1);
      rid    = id;
      rq.push_back({own, rlast, rdata});
      #1;
      e = rq.pop_front();
      chk("rready", rready, 1);
      if (e[33]) begin
        chk("dc_ret_valid", dc_ret_valid, 1);
        chk("dc_ret_data", dc_ret_data, e[31:0]);
        chk("dc_ret_last", dc_ret_last, e[32]);
        chk("ic_ret_valid_idle", ic_ret_valid, 0);
      end else begin
        chk("ic_ret_valid", ic_ret_valid, 1);
        chk("ic_ret_data", ic_ret_data, e[31:0]);
        chk("ic_ret_last", ic_ret_last, e[32]);
        chk("dc_ret_valid_idle", dc_ret_valid, 0);
      end
      tick;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int k;
    rst = 1'b1;
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_rd_type = 0; dc_rd_type = 0; dc_wr_type = 0;
    ic_rd_addr = 0; dc_rd_addr = 0; dc_wr_addr = 0;
    dc_wr_wstrb = 0; dc_wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;

    // reset state
    tick; tick;
    chk("rst_dc_wr_rdy", dc_wr_rdy, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_dc_wr_rdy", dc_wr_rdy, 1);
    chk("const_burst", {arburst, awburst, awid, wid}, {2'b01, 2'b01, 4'd1, 4'd1});
    tick;

    // icache line read
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
    #1;
    chk("ic_rd_rdy", ic_rd_rdy, 1);
    chk("dc_rd_rdy_none", dc_rd_rdy, 0);
    tick;
    ic_rd_req = 0;
    ar_phase(4'd0, 32'h1C00_0040, 8'd3, 3'd2);
    r_beats(1'b0, 4, 32'hA000_0000, 4'd0);

    // simultaneous requests: dcache first, icache the cycle after rlast
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0080;
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_4000;
    #1;
    chk("prio_dc_rdy", dc_rd_rdy, 1);
    chk("prio_ic_rdy", ic_rd_rdy, 0);
    tick;
    dc_rd_req = 0;
    ar_phase(4'd1, 32'h0000_4000, 8'd0, 3'd2);
    r_beats(1'b1, 1, 32'hB000_0000, 4'd1);
    #1;
    chk("ic_after_rlast", ic_rd_rdy, 1);
    tick;
    ic_rd_req = 0;
    ar_phase(4'd0, 32'h1C00_0080, 8'd3, 3'd2);
    r_beats(1'b0, 4, 32'hC000_0000, 4'd0);

    // uncached byte read; a wrong rid still goes to the owner
    dc_rd_req = 1; dc_rd_type = 3'b000; dc_rd_addr = 32'hBFAF_8003;
    #1;
    chk("byte_rdy", dc_rd_rdy, 1);
    tick;
    dc_rd_req = 0;
    ar_phase(4'd1, 32'hBFAF_8003, 8'd0, 3'd0);
    r_beats(1'b1, 1, 32'h0000_00EE, 4'd0);

    // dcache line write with toggling wready
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230; dc_wr_wstrb = 4'h0;
    dc_wr_data = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    #1;
    chk("wr_rdy_idle", dc_wr_rdy, 1);
    wq.push_back(32'hD0D0_D0D0); wq.push_back(32'hD1D1_D1D1);
    wq.push_back(32'hD2D2_D2D2); wq.push_back(32'hD3D3_D3D3);
    tick;
    dc_wr_req = 0;
    #1;
    chk("wr_rdy_busy", dc_wr_rdy, 0);
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, 32'h0000_1230);
    chk("awlen_line", awlen, 3);
    chk("awsize_line", awsize, 2);
    awready = 1;
    tick;
    awready = 0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      wready = c[0];
      #1;
      chk("wvalid", wvalid, 1);
      chk("wr_rdy_wdata", dc_wr_rdy, 0);
      if (wready) begin
        w = wq.pop_front();
        chk("wdata", wdata, w);
        chk("wstrb_line", wstrb, 4'hf);
        chk("wlast", wlast, (k == 3));
        k++;
      end
      tick;
    end
    wready = 0;
    chk("w_beat_count", k, 4);
    #1;
    chk("bready", bready, 1);
    chk("wvalid_resp", wvalid, 0);
    tick;
    bvalid = 1;
    #1;
    chk("bready_b", bready, 1);
    chk("wr_rdy_at_b", dc_wr_rdy, 0);
    tick;
    bvalid = 0;
    #1;
    chk("wr_rdy_after_b", dc_wr_rdy, 1);

    // pending write blocks a same-line read; another line is served meanwhile
    dc_wr_req = 1; dc_wr_type = 3'b010; dc_wr_addr = 32'h0000_1230; dc_wr_wstrb = 4'h3;
    dc_wr_data = {96'h0, 32'h5A5A_1234};
    wq.push_back(32'h5A5A_1234);
    tick;
    dc_wr_req = 0;
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_1238;
    ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_2000;
    #1;
    chk("blocked_dc_rdy", dc_rd_rdy, 0);
    chk("unblocked_ic_rdy", ic_rd_rdy, 1);
    tick;
    ic_rd_req = 0;
    chk("aw_single", {awvalid, awlen, awsize}, {1'b1, 8'd0, 3'd2});
    arready = 1; awready = 1;
    #1;
    chk("arid_ic", arid, 0);
    tick;
    arready = 0; awready = 0;
    rvalid = 1; rdata = 32'h2000_AAAA; rlast = 1; rid = 0; wready = 1;
    #1;
    chk("concurrent_ic_ret", {ic_ret_valid, ic_ret_last, ic_ret_data}, {2'b11, 32'h2000_AAAA});
    w = wq.pop_front();
    chk("wdata_single", wdata, w);
    chk("wstrb_single", wstrb, 4'h3);
    chk("wlast_single", wlast, 1);
    tick;
    rvalid = 0; rlast = 0; wready = 0;
    #1;
    chk("still_blocked", dc_rd_rdy, 0);
    bvalid = 1;
    #1;
    chk("blocked_at_b", dc_rd_rdy, 0);
    tick;
    bvalid = 0;
    #1;
    chk("unblocked_after_b", dc_rd_rdy, 1);
    tick;
    dc_rd_req = 0;
    ar_phase(4'd1, 32'h0000_1238, 8'd0, 3'd2);
    r_beats(1'b1, 1, 32'hD00D_0001, 4'd1);

    // reset in the middle of a read burst and a write burst
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0100;
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_3000; dc_wr_wstrb = 4'h0;
    dc_wr_data = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    #1;
    chk("mid_ic_rdy", ic_rd_rdy, 1);
    tick;
    ic_rd_req = 0; dc_wr_req = 0;
    arready = 1; awready = 1;
    tick;
    arready = 0; awready = 0;
    rvalid = 1; rdata = 32'hE000_0000; rlast = 0; rid = 0; wready = 1;
    #1;
    chk("mid_beat0", {ic_ret_valid, wdata}, {1'b1, 32'h3333_0000});
    tick;
    rdata = 32'hE000_0001; wready = 0;
    #1;
    chk("mid_beat1", ic_ret_valid, 1);
    tick;
    rst = 1;
    tick;
    #1;
    chk("rst_mid_valids", {arvalid, awvalid, wvalid, rready, bready, ic_ret_valid}, 0);
    chk("rst_mid_wr_rdy", dc_wr_rdy, 0);
    rst = 0; rvalid = 0;
    #1;
    chk("rst_mid_wr_rdy_after", dc_wr_rdy, 1);
    dc_wr_req = 1; dc_wr_type = 3'b010; dc_wr_addr = 32'h0000_4000; dc_wr_wstrb = 4'hf;
    dc_wr_data = {64'h0, 32'h1111_1111, 32'h0BAD_F00D};
    tick;
    dc_wr_req = 0;
    awready = 1;
    tick;
    awready = 0; wready = 1;
    #1;
    chk("cnt_cleared_wdata", wdata, 32'h0BAD_F00D);
    chk("cnt_cleared_wlast", wlast, 1);
    tick;
    wready = 0; bvalid = 1;
    tick;
    bvalid = 0;
    #1;
    chk("final_wr_rdy", dc_wr_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares one AXI master port between the instruction cache and the data cache. It accepts line refills and uncached single reads from both caches through the cache-side rd_req/rd_rdy/ret_* protocol. It accepts dirty-line writebacks and uncached writes from the dcache through the wr_req/wr_rdy protocol. It sequences the AXI AR/R and AW/W/B channels, holds one pending write in a one-entry write buffer, and blocks any read to a line whose write is still pending.

## Interface
Parameters:
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ic_rd_req, dc_rd_req  in  1  read request from icache / dcache
- ic_rd_type, dc_rd_type  in  3  000 byte, 001 half, 010 word, 100 16-byte line
- ic_rd_addr, dc_rd_addr  in  ADDR_W  read address (line-aligned when type 100)
- ic_rd_rdy, dc_rd_rdy  out  1  grant; request accepted in cycle rd_req & rd_rdy
- ic_ret_valid, dc_ret_valid  out  1  returned data beat valid
- ic_ret_last, dc_ret_last  out  1  final beat
- ic_ret_data, dc_ret_data  out  32  returned beat
- dc_wr_req  in  1  write request (single-cycle, accepted when dc_wr_rdy)
- dc_wr_type  in  3  encoding as rd_type
- dc_wr_addr  in  ADDR_W  write address
- dc_wr_wstrb  in  4  byte strobe for non-line writes
- dc_wr_data  in  128  line data, word 0 in [31:0]
- dc_wr_rdy  out  1  write buffer empty
- arid, arlen, arsize, araddr, arvalid  out  4/8/3/ADDR_W/1  AXI read address
- arready  in  1
- rid, rdata, rlast, rvalid  in  4/32/1/1  AXI read data
- rready  out  1
- awaddr, awlen, awsize, awvalid  out  ADDR_W/8/3/1  AXI write address; awid=1
- awready  in  1
- wdata, wstrb, wlast, wvalid  out  32/4/1/1  AXI write data; wid=1
- wready, bvalid  in  1
- bready  out  1
- arburst=awburst=2'b01, arlock/awlock=0, arcache/awcache=0, arprot/awprot=0  out  constant

## Operation
- Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
- R_IDLE: grant by fixed priority, dcache over icache. dc_rd_rdy = dc_rd_req & ~dc_block. ic_rd_rdy = ic_rd_req & ~ic_block & ~(dc_rd_req & ~dc_block). Both rdy are 0 outside R_IDLE.
- x_block = wbuf_busy & (x_rd_addr[ADDR_W-1:4] == wbuf_addr[ADDR_W-1:4]). wbuf_busy = wstate != W_IDLE. A blocked requester waits; the other requester may still be granted.
- On accept, latch addr, type, and owner. arid = owner (0 icache, 1 dcache).
- Type 100: arlen=3, arsize=2. Other types: arlen=0, arsize=type[1:0].
- R_AR: arvalid=1, payload stable until arready. Then go to R_DATA.
- R_DATA: rready=1. Owner's ret_valid=rvalid, ret_last=rlast, ret_data=rdata, all combinational. The non-owner's ret_valid=0. A beat with rid != owner is a protocol error; it is still routed to the owner (assertion in bench). Leave on rvalid & rlast.
- Write FSM: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE. dc_wr_rdy = (wstate==W_IDLE) & ~rst.
- Accept dc_wr_req in W_IDLE: latch addr, type, wstrb, and data into the buffer, then go to W_AW.
- W_AW: awvalid=1. Line: awlen=3, awsize=2. Else: awlen=0, awsize=type[1:0]. Go to W_DATA on awready.
- W_DATA: wvalid=1. wdata = data[32*cnt +: 32], 2-bit cnt starting at 0. wstrb=4'hf for line writes, else the latched wstrb. wlast = (cnt==awlen[1:0]). cnt increments on wready; on wready & wlast go to W_RESP and clear cnt.
- W_RESP: bready=1. Go to W_IDLE on bvalid. The block is only released here; bresp is ignored.
- The read and write FSMs run independently. A read and a write may be in flight on AXI simultaneously.

## Timing
- Reset: both FSMs idle, cnt=0. All valid/rdy/ready outputs are 0. dc_wr_rdy is 0 while rst=1 and 1 from the first cycle after. Reset mid-burst abandons the transaction with no drain.
- Grant is combinational, same cycle as rd_req. arvalid rises the cycle after accept. First possible ret_valid is the cycle after arvalid&arready.
- Back-to-back reads: the next grant is available the cycle after the rlast beat.
- Write: awvalid rises the cycle after accept. The first wvalid is the cycle after the AW handshake. dc_wr_rdy rises the cycle after bvalid.
- A buffer release (bvalid) unblocks a matching read the next cycle, not the same cycle.

## Test plan
- icache line read 0x1C000040, arready=1, 4 beats → arid=0, arlen=3, arsize=2; ic_ret_* mirrors 4 beats, last on beat 4; dc_ret_valid=0.
- ic and dc request in the same cycle → dc_rd_rdy=1, ic_rd_rdy=0; icache is granted the cycle after dcache rlast.
- dcache uncached byte read 0xBFAF8003 → arlen=0, arsize=0, single beat with ret_last=1.
- dcache line write 0x00001230, data {D3,D2,D1,D0}, wready toggling → 4 W beats D0..D3 with wstrb=f, wlast on D3, bready until bvalid; dc_wr_rdy=0 throughout.
- Write to line 0x1230 pending, dcache read 0x00001238 → dc_rd_rdy stays 0 until the cycle after bvalid; an icache read to 0x2000 is granted meanwhile.
- rst asserted in R_DATA after 2 beats and W_DATA cnt=1 → the next cycle has all valids 0 and both FSMs idle; dc_wr_rdy=1 after rst drops.
